// File: rtl/vram_write_arbiter_if.sv
// vram_write_arbiter_if: requester handshakes, clear control and VRAM write-port bus
// of the arbiter, bundled so render blocks and the arbiter share one connection.
interface vram_write_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          req0, req1, gnt0, gnt1, done0, done1;
    logic [AW-1:0] addr0, addr1, madd;
    logic [DW-1:0] data0, data1, prgb;
    logic          clr_start, clr_busy, vwe;
    modport master (
        output req0, addr0, data0, req1, addr1, data1, clr_start,
        input  gnt0, done0, gnt1, done1, clr_busy, madd, vwe, prgb
    );
    modport slave (
        input  req0, addr0, data0, req1, addr1, data1, clr_start,
        output gnt0, done0, gnt1, done1, clr_busy, madd, vwe, prgb
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: round-robin sharing of the VRAM write port between two pixel
// writers, with each write held HOLD cycles and a built-in full-buffer clear engine.
module vram_write_arbiter #(
    parameter int            AW        = 15,
    parameter int            DW        = 12,
    parameter int            HOLD      = 4,
    parameter int            DEPTH     = 30000,
    parameter logic [DW-1:0] CLR_COLOR = '0
) (
    input logic                clk,
    input logic                rst_n,
    vram_write_arbiter_if.slave bus
);
    localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
    localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, CLEAR = 2'd2;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] madd_q, madd_d;
    logic [DW-1:0] prgb_q, prgb_d;
    logic          vwe_q, vwe_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic          last_q, last_d;
    logic          clr_pend_q, clr_pend_d;
    logic          clr_busy_q, clr_busy_d;
    logic [1:0]    elig;
    logic          pick;
    always_comb begin
        // a requester whose done pulse is showing still has its old req up
        elig       = {bus.req1, bus.req0} & ~done_q;
        pick       = (&elig) ? ~last_q : elig[1];
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        madd_d     = madd_q;
        prgb_d     = prgb_q;
        vwe_d      = vwe_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        last_d     = last_q;
        clr_pend_d = clr_pend_q | (bus.clr_start & (state_q != CLEAR));
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (clr_pend_q) begin
                state_d = CLEAR;
                madd_d  = '0;
                prgb_d  = CLR_COLOR;
                vwe_d   = 1'b1;
            end else if (|elig) begin
                state_d = WRITE;
                madd_d  = pick ? bus.addr1 : bus.addr0;
                prgb_d  = pick ? bus.data1 : bus.data0;
                vwe_d   = 1'b1;
                gnt_d   = pick ? 2'b10 : 2'b01;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (state_q == WRITE) begin
                state_d = IDLE;
                vwe_d   = 1'b0;
                gnt_d   = '0;
                done_d  = gnt_q;
                last_d  = gnt_q[1];
            end else if (madd_q == ADDR_LAST) begin
                state_d    = IDLE;
                vwe_d      = 1'b0;
                madd_d     = '0;
                clr_pend_d = 1'b0;
            end else begin
                madd_d = madd_q + 1'b1;
            end
        end
        clr_busy_d = clr_pend_d | (state_d == CLEAR);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            madd_q     <= '0;
            prgb_q     <= '0;
            vwe_q      <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            last_q     <= 1'b1;
            clr_pend_q <= 1'b0;
            clr_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            madd_q     <= madd_d;
            prgb_q     <= prgb_d;
            vwe_q      <= vwe_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            last_q     <= last_d;
            clr_pend_q <= clr_pend_d;
            clr_busy_q <= clr_busy_d;
        end
    end
    assign bus.gnt0     = gnt_q[0];
    assign bus.gnt1     = gnt_q[1];
    assign bus.done0    = done_q[0];
    assign bus.done1    = done_q[1];
    assign bus.madd     = madd_q;
    assign bus.prgb     = prgb_q;
    assign bus.vwe      = vwe_q;
    assign bus.clr_busy = clr_busy_q;
endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb_vram_write_arbiter: vector table, hand-written clear/reset sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_vram_write_arbiter;
    localparam int            HOLD  = 4;
    localparam int            DEPTH = 8;
    localparam logic [11:0]   CLR   = 12'hABC;
    localparam logic [14:0]   A0    = 15'h0123;
    localparam logic [11:0]   D0    = 12'hF00;
    localparam logic [14:0]   A1    = 15'h7FFF;
    localparam logic [11:0]   D1    = 12'hEEE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vram_write_arbiter_if #(.AW(15), .DW(12)) ifc ();
    vram_write_arbiter #(.AW(15), .DW(12), .HOLD(HOLD), .DEPTH(DEPTH), .CLR_COLOR(CLR)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );

    int n_chk = 0, n_fail = 0;
    bit use_model = 0;

    typedef struct {
        logic r0, r1, g0, g1, dn0, dn1, we;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic r0, logic r1, logic g0, logic g1, logic dn0, logic dn1, logic we);
        vec_t v;
        v = '{r0, r1, g0, g1, dn0, dn1, we};
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: an operation is (kind, elapsed cycles); clear address is elapsed/HOLD
    int          m_mode, m_k, m_who, m_last;
    bit          m_pend;
    bit [1:0]    m_done;
    logic [14:0] m_addr;
    logic [11:0] m_data;

    function automatic void model_reset();
        m_mode = 0; m_k = 0; m_who = 0; m_last = 1; m_pend = 0; m_done = 0;
        m_addr = 0; m_data = 0;
    endfunction

    function automatic void model_step();
        bit [1:0] el, dn;
        bit was_clear;
        dn = 0;
        was_clear = (m_mode == 2);
        el = {ifc.req1, ifc.req0} & ~m_done;
        if (m_mode == 0) begin
            if (m_pend) begin
                m_mode = 2; m_k = 0;
            end else if (el != 0) begin
                m_who  = (el == 2'b11) ? 1 - m_last : (el[1] ? 1 : 0);
                m_mode = 1; m_k = 0;
                m_addr = m_who == 1 ? ifc.addr1 : ifc.addr0;
                m_data = m_who == 1 ? ifc.data1 : ifc.data0;
            end
        end else if (m_mode == 1) begin
            m_k++;
            if (m_k == HOLD) begin
                m_mode = 0; dn[m_who] = 1'b1; m_last = m_who;
            end
        end else begin
            m_k++;
            if (m_k == DEPTH * HOLD) begin
                m_mode = 0; m_pend = 0;
            end
        end
        if (ifc.clr_start && !was_clear) m_pend = 1;
        m_done = dn;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (use_model) model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifc.req0 = 0; ifc.req1 = 0; ifc.clr_start = 0;
        ifc.addr0 = A0; ifc.data0 = D0; ifc.addr1 = A1; ifc.data1 = D1;
    endtask

    initial begin
        idle_inputs();
        #1;
        chk("rst vwe", ifc.vwe, 0);
        chk("rst gnt", {ifc.gnt1, ifc.gnt0}, 0);
        chk("rst done", {ifc.done1, ifc.done0}, 0);
        chk("rst madd", ifc.madd, 0);
        chk("rst prgb", ifc.prgb, 0);
        chk("rst busy", ifc.clr_busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // single write, stale req held one cycle past done, then tie round-robin
        for (int i = 0; i < HOLD; i++) add(1, 0, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < HOLD; i++) add(1, 1, p % 2 == 1, p % 2 == 0, 0, 0, 1);
            add(1, 1, 0, 0, p % 2 == 1, p % 2 == 0, 0);
        end
        add(0, 0, 0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            ifc.req0 = tbl[i].r0; ifc.req1 = tbl[i].r1;
            tick();
            chk($sformatf("vec%0d gnt0", i), ifc.gnt0, tbl[i].g0);
            chk($sformatf("vec%0d gnt1", i), ifc.gnt1, tbl[i].g1);
            chk($sformatf("vec%0d done0", i), ifc.done0, tbl[i].dn0);
            chk($sformatf("vec%0d done1", i), ifc.done1, tbl[i].dn1);
            chk($sformatf("vec%0d vwe", i), ifc.vwe, tbl[i].we);
            chk($sformatf("vec%0d busy", i), ifc.clr_busy, 0);
            if (tbl[i].we) begin
                chk($sformatf("vec%0d madd", i), ifc.madd, tbl[i].g1 ? A1 : A0);
                chk($sformatf("vec%0d prgb", i), ifc.prgb, tbl[i].g1 ? D1 : D0);
            end
        end

        // clear with a request arriving during it and a second clr_start ignored
        ifc.clr_start = 1;
        tick();
        ifc.clr_start = 0;
        chk("clrA pend busy", ifc.clr_busy, 1);
        chk("clrA pend vwe", ifc.vwe, 0);
        for (int k = 0; k < DEPTH * HOLD; k++) begin
            if (k == 3) ifc.req1 = 1;
            ifc.clr_start = (k == 10);
            tick();
            chk($sformatf("clrA k%0d vwe", k), ifc.vwe, 1);
            chk($sformatf("clrA k%0d madd", k), ifc.madd, k / HOLD);
            chk($sformatf("clrA k%0d prgb", k), ifc.prgb, CLR);
            chk($sformatf("clrA k%0d gnt1", k), ifc.gnt1, 0);
            chk($sformatf("clrA k%0d busy", k), ifc.clr_busy, 1);
        end
        ifc.clr_start = 0;
        tick();
        chk("clrA end vwe", ifc.vwe, 0);
        chk("clrA end busy", ifc.clr_busy, 0);
        chk("clrA end gnt1", ifc.gnt1, 0);
        tick();
        chk("clrA req1 gnt1", ifc.gnt1, 1);
        chk("clrA req1 madd", ifc.madd, A1);
        repeat (HOLD - 1) tick();
        tick();
        chk("clrA req1 done1", ifc.done1, 1);
        ifc.req1 = 0;
        tick();
        chk("clrA no restart busy", ifc.clr_busy, 0);
        chk("clrA no restart vwe", ifc.vwe, 0);

        // clear requested mid-write waits for the write, then beats pending req1
        ifc.addr0 = 15'h1234; ifc.data0 = 12'h5A5;
        ifc.req0 = 1;
        tick();
        chk("clrB w0 gnt0", ifc.gnt0, 1);
        ifc.clr_start = 1; ifc.req1 = 1;
        ifc.addr0 = 15'h0001; ifc.data0 = 12'h001;
        tick();
        ifc.clr_start = 0;
        chk("clrB w1 gnt0", ifc.gnt0, 1);
        chk("clrB w1 busy", ifc.clr_busy, 1);
        repeat (HOLD - 2) tick();
        chk("clrB last vwe", ifc.vwe, 1);
        chk("clrB last madd", ifc.madd, 15'h1234);
        chk("clrB last prgb", ifc.prgb, 12'h5A5);
        tick();
        chk("clrB done0", ifc.done0, 1);
        chk("clrB done vwe", ifc.vwe, 0);
        ifc.req0 = 0;
        tick();
        chk("clrB start vwe", ifc.vwe, 1);
        chk("clrB start gnt1", ifc.gnt1, 0);
        chk("clrB start madd", ifc.madd, 0);
        chk("clrB start prgb", ifc.prgb, CLR);
        repeat (DEPTH * HOLD - 1) tick();
        chk("clrB tail vwe", ifc.vwe, 1);
        chk("clrB tail madd", ifc.madd, DEPTH - 1);
        tick();
        chk("clrB end vwe", ifc.vwe, 0);
        chk("clrB end busy", ifc.clr_busy, 0);
        tick();
        chk("clrB req1 gnt1", ifc.gnt1, 1);
        repeat (HOLD) tick();
        chk("clrB req1 done1", ifc.done1, 1);
        ifc.req1 = 0;
        tick();

        // async reset mid-write abandons it, clears pending clear, restores tie order
        idle_inputs();
        ifc.req0 = 1;
        repeat (HOLD + 1) tick();
        chk("rstC done0", ifc.done0, 1);
        ifc.req0 = 0; ifc.req1 = 1;
        tick();
        chk("rstC gnt1", ifc.gnt1, 1);
        ifc.clr_start = 1;
        tick();
        ifc.clr_start = 0;
        #3 rst_n = 0;
        #1;
        chk("rstC vwe", ifc.vwe, 0);
        chk("rstC gnt", {ifc.gnt1, ifc.gnt0}, 0);
        chk("rstC madd", ifc.madd, 0);
        chk("rstC prgb", ifc.prgb, 0);
        chk("rstC busy", ifc.clr_busy, 0);
        @(negedge clk);
        rst_n = 1;
        ifc.req0 = 1; ifc.req1 = 1;
        tick();
        chk("rstC tie gnt0", ifc.gnt0, 1);
        chk("rstC tie gnt1", ifc.gnt1, 0);
        chk("rstC tie madd", ifc.madd, A0);

        // randomized protocol-following traffic against the model
        idle_inputs();
        rst_n = 0;
        model_reset();
        tick();
        rst_n = 1;
        use_model = 1;
        for (int c = 0; c < 2000; c++) begin
            ifc.addr0 = 15'($urandom); ifc.data0 = 12'($urandom);
            ifc.addr1 = 15'($urandom); ifc.data1 = 12'($urandom);
            ifc.clr_start = $urandom_range(0, 99) == 0;
            tick();
            chk($sformatf("rnd%0d vwe", c), ifc.vwe, m_mode != 0);
            chk($sformatf("rnd%0d gnt0", c), ifc.gnt0, m_mode == 1 && m_who == 0);
            chk($sformatf("rnd%0d gnt1", c), ifc.gnt1, m_mode == 1 && m_who == 1);
            chk($sformatf("rnd%0d done", c), {ifc.done1, ifc.done0}, m_done);
            chk($sformatf("rnd%0d busy", c), ifc.clr_busy, m_pend || m_mode == 2);
            chk($sformatf("rnd%0d excl", c), ifc.gnt0 & ifc.gnt1, 0);
            if (m_mode != 0) begin
                chk($sformatf("rnd%0d madd", c), ifc.madd, m_mode == 1 ? m_addr : 15'(m_k / HOLD));
                chk($sformatf("rnd%0d prgb", c), ifc.prgb, m_mode == 1 ? m_data : CLR);
            end
            if (ifc.req0 && ifc.done0) ifc.req0 = $urandom_range(0, 3) == 0;
            else if (!ifc.req0) ifc.req0 = $urandom_range(0, 2) == 0;
            if (ifc.req1 && ifc.done1) ifc.req1 = $urandom_range(0, 3) == 0;
            else if (!ifc.req1) ifc.req1 = $urandom_range(0, 2) == 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
